// File: rtl/led_matrix_scanner.sv
// Purpose: time-multiplexed 8x8 LED matrix row scanner with blanking gap and 16-level PWM.
// Latency: outputs are one register stage behind state/slot_cnt; new frame latched at 7->0 wrap.
// Backpressure: none; free-running scan, input frame sampled only at latch points.
module led_matrix_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYC      = 40,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] brightness,
  input  logic [7:0] row_1,
  input  logic [7:0] row_2,
  input  logic [7:0] row_3,
  input  logic [7:0] row_4,
  input  logic [7:0] row_5,
  input  logic [7:0] row_6,
  input  logic [7:0] row_7,
  input  logic [7:0] row_8,
  output logic [7:0] row_sel,
  output logic [7:0] col_drv,
  output logic [2:0] scan_row,
  output logic       frame_tick
);

  // The active window (CLK_DIV-BLANK_CYC) is split into 16 equal PWM sub-slots.
  localparam int SUB = (CLK_DIV - BLANK_CYC) / 16;
  localparam int CW  = $clog2(CLK_DIV);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [7:0]    ROW_IDLE   = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]    COL_IDLE   = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE, OFF} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          slot_last;
  logic          latch_en;
  logic          drive_now;
  logic [CW:0]   drive_end;
  logic [7:0]    row_onehot;
  logic [7:0]    shadow [8];
  logic [3:0]    shadow_bri;

  assign slot_last = (slot_cnt == CNT_LAST);
  assign cnt_nxt   = slot_last ? '0 : slot_cnt + CW'(1);

  // First slot_cnt value past the lit part of the window: BLANK + (bri+1)*SUB.
  // At brightness 15 this equals CLK_DIV, which the counter never reaches.
  assign drive_end = (CW+1)'(BLANK_CYC + SUB) + (CW+1)'(SUB) * (CW+1)'(shadow_bri);

  // Latch a new frame when the scan starts and at every 7->0 row wrap.
  assign latch_en  = enable && ((state == IDLE) || (slot_last && (scan_row == 3'd7)));

  // Gated by enable so a drop of enable blanks the pins on the very next edge.
  assign drive_now = enable && (state == DRIVE);

  assign row_onehot = 8'b1 << scan_row;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: blank gap, PWM-lit window, dark tail, wrap back to blank.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = BLANK;
      BLANK:   if (slot_cnt == BLANK_LAST) state_nxt = DRIVE;
      DRIVE: begin
        if (slot_last)                          state_nxt = BLANK;
        else if ({1'b0, cnt_nxt} >= drive_end)  state_nxt = OFF;
      end
      OFF:     if (slot_last) state_nxt = BLANK;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Slot counter and row index; both held at zero while idle or disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      scan_row <= 3'd0;
    end else if (!enable || (state == IDLE)) begin
      slot_cnt <= '0;
      scan_row <= 3'd0;
    end else begin
      slot_cnt <= cnt_nxt;
      if (slot_last) scan_row <= scan_row + 3'd1;
    end
  end

  // Shadow frame and brightness; only updated at latch points so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
      shadow_bri <= 4'd0;
    end else if (latch_en) begin
      shadow[0]  <= row_1;
      shadow[1]  <= row_2;
      shadow[2]  <= row_3;
      shadow[3]  <= row_4;
      shadow[4]  <= row_5;
      shadow[5]  <= row_6;
      shadow[6]  <= row_7;
      shadow[7]  <= row_8;
      shadow_bri <= brightness;
    end
  end

  // Registered pin drivers; XOR with the idle level applies the configured polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sel    <= ROW_IDLE;
      col_drv    <= COL_IDLE;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= latch_en;
      if (drive_now) begin
        row_sel <= row_onehot ^ ROW_IDLE;
        col_drv <= shadow[scan_row] ^ COL_IDLE;
      end else begin
        row_sel <= ROW_IDLE;
        col_drv <= COL_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Purpose: directed bench for led_matrix_scanner at CLK_DIV=32, BLANK_CYC=16 (one clock per PWM step).
// Latency: sample s is the negedge after the s-th posedge following enable; pins show slot_cnt s-1.
// Backpressure: not applicable; stimulus is free-running.
module tb_led_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] brightness;
  logic [7:0] rows_in [8];
  logic [7:0] row_sel;
  logic [7:0] col_drv;
  logic [2:0] scan_row;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  led_matrix_scanner #(
    .CLK_DIV(32), .BLANK_CYC(16), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
    .row_1(rows_in[0]), .row_2(rows_in[1]), .row_3(rows_in[2]), .row_4(rows_in[3]),
    .row_5(rows_in[4]), .row_6(rows_in[5]), .row_7(rows_in[6]), .row_8(rows_in[7]),
    .row_sel(row_sel), .col_drv(col_drv), .scan_row(scan_row), .frame_tick(frame_tick)
  );

  // Pins at sample s are lit when slot_cnt (s-1)%32 lies in [16, 16+bri].
  function automatic bit m_drive(int s, int bri);
    int cnt;
    if (s < 1) return 1'b0;
    cnt = (s - 1) % 32;
    return (cnt >= 16) && ((cnt - 16) <= bri);
  endfunction

  function automatic int m_idx(int s);
    return (s > 0) ? ((s - 1) / 32) % 8 : 0;
  endfunction

  task automatic start_scan(input logic [7:0] f [8], input logic [3:0] bri);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rows_in    = f;
    brightness = bri;
    enable     = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; brightness = 4'd0;
    for (int i = 0; i < 8; i++) rows_in[i] = 8'h00;
    #12;
    tests++; if (row_sel !== 8'hFF) begin fails++; $display("FAIL reset_row_sel got=%h exp=ff", row_sel); end
    tests++; if (col_drv !== 8'h00) begin fails++; $display("FAIL reset_col_drv got=%h exp=00", col_drv); end
    tests++; if (scan_row !== 3'd0) begin fails++; $display("FAIL reset_scan_row got=%0d exp=0", scan_row); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tests++;
      if (row_sel !== 8'hFF || col_drv !== 8'h00 || frame_tick !== 1'b0) begin
        fails++;
        $display("FAIL disabled_dark c=%0d row_sel=%h col_drv=%h tick=%b exp ff/00/0", c, row_sel, col_drv, frame_tick);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] f [8];
    logic [7:0] er, ec;
    logic [2:0] es;
    bit drv;
    for (int i = 0; i < 8; i++) f[i] = 8'h00;
    f[0] = 8'hA5;
    start_scan(f, 4'd15);
    for (int s = 0; s < 320; s++) begin
      @(negedge clk);
      drv = m_drive(s, 15);
      er  = drv ? ~(8'b1 << m_idx(s)) : 8'hFF;
      ec  = drv ? f[m_idx(s)] : 8'h00;
      es  = 3'((s / 32) % 8);
      tests++;
      if (row_sel !== er || col_drv !== ec || scan_row !== es || frame_tick !== (s % 256 == 0)) begin
        fails++;
        $display("FAIL basic s=%0d row_sel=%h/%h col_drv=%h/%h scan_row=%0d/%0d tick=%b (got/exp)",
                 s, row_sel, er, col_drv, ec, scan_row, es, frame_tick);
      end
      if (s == 17) begin
        tests++;
        if (row_sel !== 8'hFE || col_drv !== 8'hA5) begin
          fails++; $display("FAIL basic_first_drive row_sel=%h col_drv=%h exp fe/a5", row_sel, col_drv);
        end
      end
      if (s == 49) begin
        tests++;
        if (row_sel !== 8'hFD || col_drv !== 8'h00) begin
          fails++; $display("FAIL basic_row1 row_sel=%h col_drv=%h exp fd/00", row_sel, col_drv);
        end
      end
    end
  endtask

  task automatic test_brightness();
    logic [7:0] f [8];
    logic [7:0] er, ec;
    bit drv;
    int lit;
    for (int i = 0; i < 8; i++) f[i] = 8'hFF;
    start_scan(f, 4'd3);
    lit = 0;
    for (int s = 0; s < 520; s++) begin
      @(negedge clk);
      drv = m_drive(s, 3);
      er  = drv ? ~(8'b1 << m_idx(s)) : 8'hFF;
      ec  = drv ? 8'hFF : 8'h00;
      tests++;
      if (row_sel !== er || col_drv !== ec || frame_tick !== (s % 256 == 0)) begin
        fails++;
        $display("FAIL bri3 s=%0d row_sel=%h/%h col_drv=%h/%h tick=%b (got/exp)", s, row_sel, er, col_drv, ec, frame_tick);
      end
      if (row_sel !== 8'hFF) lit++;
      if (s > 0 && s % 32 == 0) begin
        tests++;
        if (lit !== 4) begin fails++; $display("FAIL bri3_lit_clocks s=%0d got=%0d exp=4", s, lit); end
        lit = 0;
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [7:0] f [8];
    logic [7:0] er, ec;
    bit drv;
    for (int i = 0; i < 8; i++) f[i] = 8'h00;
    start_scan(f, 4'd15);
    for (int s = 0; s < 530; s++) begin
      @(negedge clk);
      drv = m_drive(s, 15);
      er  = drv ? ~(8'b1 << m_idx(s)) : 8'hFF;
      ec  = (drv && s >= 257 && m_idx(s) == 2) ? 8'hFF : 8'h00;
      tests++;
      if (row_sel !== er || col_drv !== ec || frame_tick !== (s % 256 == 0)) begin
        fails++;
        $display("FAIL tearing s=%0d row_sel=%h/%h col_drv=%h/%h tick=%b (got/exp)", s, row_sel, er, col_drv, ec, frame_tick);
      end
      if (s == 90) begin
        tests++;
        if (row_sel !== 8'hFB || col_drv !== 8'h00) begin
          fails++; $display("FAIL tearing_old_frame row_sel=%h col_drv=%h exp fb/00", row_sel, col_drv);
        end
      end
      if (s == 340) begin
        tests++;
        if (row_sel !== 8'hFB || col_drv !== 8'hFF) begin
          fails++; $display("FAIL tearing_new_frame row_sel=%h col_drv=%h exp fb/ff", row_sel, col_drv);
        end
      end
      if (s == 40) rows_in[2] = 8'hFF;
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] f [8];
    logic [7:0] er, ec;
    bit drv;
    for (int i = 0; i < 8; i++) f[i] = 8'(8'h11 * (i + 1));
    start_scan(f, 4'd15);
    for (int s = 0; s <= 180; s++) begin
      @(negedge clk);
      drv = m_drive(s, 15);
      er  = drv ? ~(8'b1 << m_idx(s)) : 8'hFF;
      ec  = drv ? f[m_idx(s)] : 8'h00;
      tests++;
      if (row_sel !== er || col_drv !== ec) begin
        fails++;
        $display("FAIL pre_drop s=%0d row_sel=%h/%h col_drv=%h/%h (got/exp)", s, row_sel, er, col_drv, ec);
      end
    end
    enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (row_sel !== 8'hFF || col_drv !== 8'h00 || scan_row !== 3'd0 || frame_tick !== 1'b0) begin
        fails++;
        $display("FAIL drop_dark c=%0d row_sel=%h col_drv=%h scan_row=%0d tick=%b exp ff/00/0/0",
                 c, row_sel, col_drv, scan_row, frame_tick);
      end
    end
    enable = 1'b1;
    for (int s = 0; s < 60; s++) begin
      @(negedge clk);
      drv = m_drive(s, 15);
      er  = drv ? ~(8'b1 << m_idx(s)) : 8'hFF;
      ec  = drv ? f[m_idx(s)] : 8'h00;
      tests++;
      if (row_sel !== er || col_drv !== ec || scan_row !== 3'((s / 32) % 8) || frame_tick !== (s == 0)) begin
        fails++;
        $display("FAIL reenable s=%0d row_sel=%h/%h col_drv=%h/%h scan_row=%0d tick=%b (got/exp)",
                 s, row_sel, er, col_drv, ec, scan_row, frame_tick);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] f [8];
    for (int i = 0; i < 8; i++) f[i] = 8'h00;
    f[0] = 8'h81;
    start_scan(f, 4'd15);
    repeat (21) @(negedge clk);
    tests++;
    if (row_sel !== 8'hFE || col_drv !== 8'h81) begin
      fails++; $display("FAIL pre_reset_drive row_sel=%h col_drv=%h exp fe/81", row_sel, col_drv);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (row_sel !== 8'hFF || col_drv !== 8'h00 || scan_row !== 3'd0 || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL async_reset row_sel=%h col_drv=%h scan_row=%0d tick=%b exp ff/00/0/0",
               row_sel, col_drv, scan_row, frame_tick);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_brightness();
    test_no_tearing();
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
